// File: rtl/ara_pkg.sv
// ara_pkg: shared element type and local consumer indices
package ara_pkg;
    localparam int unsigned ELEN = 64;
    typedef logic [ELEN-1:0] elen_t;
    localparam int unsigned VMFPU = 0;
    localparam int unsigned VALU  = 1;
endpackage

// File: rtl/bc_operand_fanout_if.sv
// bc_operand_fanout_if: config, upstream, next-lane and local consumer handshakes
interface bc_operand_fanout_if #(
    parameter int unsigned NrConsumers = 2,
    parameter int unsigned LenWidth    = 16
) ();
    logic                      cfg_valid_i;
    logic                      cfg_ready_o;
    logic [LenWidth-1:0]       cfg_len_i;
    logic [NrConsumers-1:0]    cfg_cons_mask_i;
    logic                      cfg_fwd_i;
    logic                      bc_valid_i;
    logic                      bc_ready_o;
    ara_pkg::elen_t            bc_data_i;
    logic                      bc_valid_o;
    logic                      bc_ready_i;
    ara_pkg::elen_t            bc_data_o;
    logic [NrConsumers-1:0]    cons_valid_o;
    logic [NrConsumers-1:0]    cons_ready_i;
    ara_pkg::elen_t            cons_data_o;
    logic                      done_o;

    modport master (
        output cfg_valid_i, cfg_len_i, cfg_cons_mask_i, cfg_fwd_i,
        output bc_valid_i, bc_data_i, bc_ready_i, cons_ready_i,
        input  cfg_ready_o, bc_ready_o, bc_valid_o, bc_data_o,
        input  cons_valid_o, cons_data_o, done_o
    );

    modport slave (
        input  cfg_valid_i, cfg_len_i, cfg_cons_mask_i, cfg_fwd_i,
        input  bc_valid_i, bc_data_i, bc_ready_i, cons_ready_i,
        output cfg_ready_o, bc_ready_o, bc_valid_o, bc_data_o,
        output cons_valid_o, cons_data_o, done_o
    );
endinterface

// File: rtl/fifo_v3.sv
// fifo_v3: registered FIFO; a push while full is taken when a pop frees the slot in the same cycle
module fifo_v3 #(
    parameter int unsigned DEPTH = 2,
    parameter type         dtype = logic
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic flush_i,
    output logic full_o,
    output logic empty_o,
    input  dtype data_i,
    input  logic push_i,
    output dtype data_o,
    input  logic pop_i
);
    localparam int unsigned AW = DEPTH > 1 ? $clog2(DEPTH) : 1;
    localparam int unsigned CW = $clog2(DEPTH + 1);

    logic [AW-1:0] rd_ptr_q, wr_ptr_q;
    logic [CW-1:0] cnt_q;
    dtype          mem_q [DEPTH];
    logic          do_push, do_pop;

    assign full_o  = cnt_q == CW'(DEPTH);
    assign empty_o = cnt_q == '0;
    assign data_o  = mem_q[rd_ptr_q];
    assign do_pop  = pop_i & ~empty_o;
    assign do_push = push_i & (~full_o | do_pop);

    // pointer and fill-level bookkeeping
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            cnt_q    <= '0;
        end else if (flush_i) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            if (do_pop)  rd_ptr_q <= rd_ptr_q == AW'(DEPTH - 1) ? '0 : rd_ptr_q + 1'b1;
            if (do_push) wr_ptr_q <= wr_ptr_q == AW'(DEPTH - 1) ? '0 : wr_ptr_q + 1'b1;
            cnt_q <= cnt_q + CW'(do_push) - CW'(do_pop);
        end
    end

    // storage needs no reset; occupancy is tracked by the counter
    always_ff @(posedge clk_i) begin
        if (do_push) mem_q[wr_ptr_q] <= data_i;
    end
endmodule

// File: rtl/bc_operand_fanout.sv
// bc_operand_fanout: forks each broadcast element to local consumers and a buffered next-lane forward
module bc_operand_fanout
    import ara_pkg::*;
#(
    parameter int unsigned BufDepth    = 2,
    parameter int unsigned NrConsumers = 2,
    parameter int unsigned LenWidth    = 16
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic                flush_i,
    bc_operand_fanout_if.slave  bus
);
    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] ACTIVE = 2'd1;
    localparam logic [1:0] DRAIN  = 2'd2;

    logic [1:0]             state_q;
    logic [LenWidth-1:0]    cnt_q;
    logic [NrConsumers-1:0] mask_q, taken_q, cons_hs, cons_ok;
    logic                   fwd_q, taken_fwd_q, zero_done_q;
    logic                   fifo_full, fifo_empty, push, pop;
    logic                   active, cfg_hs, fwd_ok, accept;

    assign active           = state_q == ACTIVE;
    assign bus.cfg_ready_o  = state_q == IDLE;
    assign cfg_hs           = bus.cfg_valid_i & bus.cfg_ready_o;
    assign bus.cons_data_o  = bus.bc_data_i;
    assign bus.cons_valid_o = {NrConsumers{bus.bc_valid_i & active}} & mask_q & ~taken_q;
    assign cons_hs          = bus.cons_valid_o & bus.cons_ready_i;
    assign cons_ok          = ~mask_q | taken_q | cons_hs;
    assign bus.bc_valid_o   = ~fifo_empty;
    assign pop              = bus.bc_valid_o & bus.bc_ready_i;
    assign push             = bus.bc_valid_i & active & fwd_q & ~taken_fwd_q & (~fifo_full | pop);
    assign fwd_ok           = ~fwd_q | taken_fwd_q | push;
    assign bus.bc_ready_o   = active & (&cons_ok) & fwd_ok;
    assign accept           = bus.bc_ready_o & bus.bc_valid_i;
    assign bus.done_o       = ~flush_i & ((state_q == DRAIN & fifo_empty) | zero_done_q);

    fifo_v3 #(
        .DEPTH (BufDepth),
        .dtype (elen_t)
    ) i_fifo (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .flush_i (flush_i),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .data_i  (bus.bc_data_i),
        .push_i  (push),
        .data_o  (bus.bc_data_o),
        .pop_i   (pop)
    );

    // broadcast sequencing: latch config, track per-target delivery, count elements, drain forward buffer
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            mask_q      <= '0;
            fwd_q       <= 1'b0;
            taken_q     <= '0;
            taken_fwd_q <= 1'b0;
            zero_done_q <= 1'b0;
        end else if (flush_i) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            taken_q     <= '0;
            taken_fwd_q <= 1'b0;
            zero_done_q <= 1'b0;
        end else begin
            zero_done_q <= cfg_hs && bus.cfg_len_i == '0;
            if (cfg_hs && bus.cfg_len_i != '0) begin
                state_q <= ACTIVE;
                cnt_q   <= bus.cfg_len_i;
                mask_q  <= bus.cfg_cons_mask_i;
                fwd_q   <= bus.cfg_fwd_i;
            end else if (accept) begin
                taken_q     <= '0;
                taken_fwd_q <= 1'b0;
                cnt_q       <= cnt_q - 1'b1;
                if (cnt_q == LenWidth'(1)) state_q <= DRAIN;
            end else if (active) begin
                taken_q     <= taken_q | cons_hs;
                taken_fwd_q <= taken_fwd_q | push;
            end else if (state_q == DRAIN && fifo_empty) begin
                state_q <= IDLE;
            end
        end
    end
endmodule

// File: doc/bc_operand_fanout.md
BC_OPERAND_FANOUT -- requirements
Module: bc_operand_fanout

Interface
REQ-001 Parameter BufDepth, default 2: forward-buffer depth in elen_t entries (≥1).
REQ-002 Parameter NrConsumers, default 2: local consumers (index 0 = VMFPU, 1 = VALU).
REQ-003 Parameter LenWidth, default 16: element-count width.
REQ-004 clk_i  in  1  clock; one clock domain.
REQ-005 rst_ni  in  1  asynchronous active-low reset.
REQ-006 flush_i  in  1  synchronous abort of the current broadcast.
REQ-007 cfg_valid_i / cfg_ready_o  in/out  1  handshake that starts a broadcast.
REQ-008 cfg_len_i  in  LenWidth  elements in the broadcast.
REQ-009 cfg_cons_mask_i  in  NrConsumers  local consumers that receive each element.
REQ-010 cfg_fwd_i  in  1  forward elements to the next lane (0 = last lane).
REQ-011 bc_valid_i / bc_ready_o  in/out  1, bc_data_i in elen_t  upstream lane / broadcast buffer.
REQ-012 bc_valid_o / bc_ready_i  out/in  1, bc_data_o out elen_t  next lane.
REQ-013 cons_valid_o / cons_ready_i  out/in  NrConsumers, cons_data_o out elen_t  local consumers.
REQ-014 done_o  out  1  one-cycle pulse when a broadcast finishes.

Function
REQ-015 FSM states IDLE, ACTIVE, DRAIN; cfg_ready_o = 1 only in IDLE.
REQ-016 IDLE, cfg handshake with cfg_len_i>0: latch len, mask and fwd; go to ACTIVE.
REQ-017 IDLE, cfg handshake with cfg_len_i==0: stay IDLE; pulse done_o in the next cycle.
REQ-018 cons_data_o = bc_data_i, combinational; no local buffering.
REQ-019 cons_valid_o[i] = bc_valid_i & ACTIVE & mask[i] & ~taken[i]; it never depends on any ready.
REQ-020 taken[i] sets on a cons_valid_o[i] & cons_ready_i[i] handshake that does not complete the element.
REQ-021 The forward target is a single taken_fwd flag: it sets on a FIFO push and is enabled only if fwd is latched.
REQ-022 An element is accepted (bc_ready_o = 1) in the cycle every enabled target is either taken or handshaking in that cycle.
REQ-023 On acceptance, clear all taken flags and decrement the counter.
REQ-024 On acceptance of the element with count==1, move to DRAIN.
REQ-025 Forward FIFO: push when bc_valid_i & fwd & ~taken_fwd & ~full; bc_valid_o = ~empty; pop on bc_valid_o & bc_ready_i.
REQ-026 A simultaneous push and pop is legal at any fill level, including full (pop frees the slot in the same cycle).
REQ-027 DRAIN: stay until the FIFO is empty, then go to IDLE and pulse done_o in the same cycle.
REQ-028 With fwd=0, DRAIN lasts exactly one cycle.
REQ-029 bc_ready_o = 0 outside ACTIVE.
REQ-030 Each upstream element reaches each enabled target exactly once, in order.
REQ-031 Latency: local consumers 0 cycles; next lane ≥1 cycle (FIFO registered).
REQ-032 flush_i (highest priority) clears FIFO, taken flags and counter; state IDLE; no done_o pulse.

Reset
REQ-033 Reset values: state IDLE; FIFO empty; taken flags 0; counter 0; latched cfg 0; done_o 0.
REQ-034 All outputs are then inactive: bc_valid_o=0, cons_valid_o=0, bc_ready_o=0; cfg_ready_o=1.
REQ-035 Reset mid-broadcast abandons it; no done_o pulse.

Structure
REQ-036 elen_t and the consumer index constants (VMFPU=0, VALU=1) reside in ara_pkg.
REQ-037 The state enum is local to the module.
REQ-038 The forward buffer is one fifo_v3 instance (DEPTH=BufDepth, dtype=elen_t), with flush_i on its flush port.

Verification
REQ-039 cfg len=4, mask=2'b11, fwd=1, all readies 1, data A..D → 4 elements on each consumer on the accept cycles; bc_data_o A..D one cycle later; done_o after the FIFO drains.
REQ-040 Fork stall, len=1: VMFPU ready at cycle 0, VALU ready only at cycle 3 → VMFPU sees one handshake only; bc_ready_o high only at cycle 3.
REQ-041 Forward backpressure, BufDepth=2, bc_ready_i=0, len=3 → 2 elements accepted, third stalls. Raise bc_ready_i → third accepted, FIFO drains, done_o pulses.
REQ-042 Last lane, fwd=0, mask=2'b01, len=2 → bc_valid_o never asserted; done_o 1 cycle after the 2nd accept.
REQ-043 cfg len=0 → done_o in the next cycle; bc_ready_o stays 0.
REQ-044 Mid-broadcast events: flush_i → IDLE next cycle, FIFO empty, no done_o; separately, rst_ni low mid-broadcast → all outputs at reset values asynchronously.
